// File: rtl/cfg_dispatch.sv
// cfg_dispatch: queues 32-bit configuration commands {addr, mod, data} and
// ships each one out MSB first over a three-device SPI bus, followed by a
// trigger pulse on le. Address 3 has no device and is flagged in err_addr.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting; pops the FIFO head into the shift register when queued
// LOAD   | decode address: select device and present bit 31, or flag error
// SETUP  | chip select low, sclk low, CLK_DIV cycles before the first edge
// SHIFT  | 32 bits, each CLK_DIV cycles low then CLK_DIV cycles high
// HOLD   | chip select released, CLK_DIV cycles before the latch pulse
// LATCH  | le high for LE_HOLD cycles
module cfg_dispatch #(
    parameter int CLK_DIV    = 4,
    parameter int LE_HOLD    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd_addr,
    input  logic [5:0]                    cmd_mod,
    input  logic [23:0]                   cmd_data,
    input  logic                          ovf_clr,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    output logic [2:0]                    spi_cs_n,
    output logic                          le,
    output logic                          busy,
    output logic                          ovf,
    output logic                          err_addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_LATCH = 3'd5;

    localparam logic [7:0]       DIV_M1  = 8'(CLK_DIV - 1);
    localparam logic [7:0]       LE_M1   = 8'(LE_HOLD - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [2:0]       state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [2:0]       cs_n_q, cs_n_d;
    logic             le_q, le_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];

    logic pop;
    logic push;
    logic full;
    logic ovf_set;
    logic err_set;

    // Sequencer: every SPI/le output is registered so nothing glitches.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        le_d      = le_q;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (shreg_q[31:30] == 2'b11) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cs_n_d  = ~(3'b001 << shreg_q[31:30]);
                    mosi_d  = shreg_q[31];
                    timer_d = DIV_M1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_q == 8'd0) begin
                    timer_d   = DIV_M1;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    timer_d = DIV_M1;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: the only point where mosi may move.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 5'd31) begin
                            cs_n_d  = 3'b111;
                            mosi_d  = 1'b0;
                            state_d = ST_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shreg_d   = {shreg_q[30:0], 1'b0};
                            mosi_d    = shreg_q[30];
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (timer_q == 8'd0) begin
                    le_d    = 1'b1;
                    timer_d = LE_M1;
                    state_d = ST_LATCH;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_LATCH: begin
                if (timer_q == 8'd0) begin
                    le_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command FIFO and sticky flags; a pop frees the slot a same-cycle push uses.
    always_comb begin
        full     = (cnt_q == DEPTH_C);
        push     = cmd_valid && (!full || pop);
        ovf_set  = cmd_valid && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_addr, cmd_mod, cmd_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        err_d = err_set ? 1'b1 : (ovf_clr ? 1'b0 : err_q);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= 8'd0;
            bit_cnt_q <= 5'd0;
            shreg_q   <= 32'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 3'b111;
            le_q      <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            le_q      <= le_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset: entries are only read behind the count.
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;
    assign le       = le_q;
    assign busy     = (state_q != ST_IDLE);
    assign ovf      = ovf_q;
    assign err_addr = err_q;
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_cfg_dispatch.sv
// Bench for cfg_dispatch: a transaction-level model predicts every output
// cycle by cycle from the position inside the current write, and an SPI
// monitor decodes the bus and checks framing, word content and le timing.
module tb_cfg_dispatch;

    localparam int CD    = 4;
    localparam int LH    = 10;
    localparam int DEPTH = 4;
    localparam int DUR   = 66 * CD + LH + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [5:0]  cmd_mod = 6'd0;
    logic [23:0] cmd_data = 24'd0;
    logic        ovf_clr = 1'b0;
    logic        spi_sclk, spi_mosi, le, busy, ovf, err_addr;
    logic [2:0]  spi_cs_n;
    logic [2:0]  fifo_cnt;

    cfg_dispatch #(.CLK_DIV(CD), .LE_HOLD(LH), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid),
        .cmd_addr(cmd_addr), .cmd_mod(cmd_mod), .cmd_data(cmd_data),
        .ovf_clr(ovf_clr), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .le(le), .busy(busy), .ovf(ovf),
        .err_addr(err_addr), .fifo_cnt(fifo_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    logic [31:0] exp_words[$];
    logic [31:0] cur_word = 32'd0;
    bit          cur_valid = 1'b0;
    int          busy_r = 0;
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    int          cyc = 0;
    bit          mon_abort = 1'b0;

    task automatic model_step();
        bit pop, push_ok, err_set, ovf_set;
        cyc++;
        if (!sys_rst) begin
            mq.delete();
            exp_words.delete();
            busy_r    = 0;
            cur_valid = 1'b0;
            m_ovf     = 1'b0;
            m_err     = 1'b0;
            mon_abort = 1'b1;
            return;
        end
        pop     = (busy_r == 0) && (mq.size() > 0);
        err_set = (busy_r > 0) && !cur_valid;
        push_ok = cmd_valid && ((mq.size() < DEPTH) || pop);
        ovf_set = cmd_valid && !push_ok;
        if (busy_r > 0) busy_r--;
        if (pop) begin
            cur_word  = mq.pop_front();
            cur_valid = (cur_word[31:30] != 2'b11);
            busy_r    = cur_valid ? DUR : 1;
            if (cur_valid) exp_words.push_back(cur_word);
        end
        if (push_ok) mq.push_back({cmd_addr, cmd_mod, cmd_data});
        m_ovf = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_err = err_set ? 1'b1 : (ovf_clr ? 1'b0 : m_err);
    endtask

    // Expected {cs_n, sclk, mosi, le, busy, ovf, err_addr} for the current cycle.
    function automatic logic [8:0] exp_vec();
        logic [2:0] cs = 3'b111;
        logic sc = 1'b0, mo = 1'b0, l = 1'b0, b = 1'b0;
        int t, s, bi;
        if (busy_r > 0) begin
            b = 1'b1;
            if (cur_valid) begin
                t = DUR - busy_r;
                if (t >= 1 && t <= 65 * CD) begin
                    cs[int'(cur_word[31:30])] = 1'b0;
                    if (t <= CD) mo = cur_word[31];
                    else begin
                        s  = t - CD - 1;
                        bi = s / (2 * CD);
                        sc = (s % (2 * CD)) >= CD;
                        mo = cur_word[31 - bi];
                    end
                end else if (t > 66 * CD) l = 1'b1;
            end
        end
        return {cs, sc, mo, l, b, m_ovf, m_err};
    endfunction

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    // ---------------- monitor ----------------
    logic [2:0]  prev_cs = 3'b111;
    logic        prev_sclk = 1'b0, prev_le = 1'b0;
    bit          in_txn = 1'b0, le_wait = 1'b0;
    int          cs_start = 0, cs_rise = 0, le_start = 0, edges = 0;
    int          txn_done = 0, peak = 0, le_seen = 0;
    logic [31:0] word = 32'd0;

    task automatic mon_step();
        chk("outputs", 32'({spi_cs_n, spi_sclk, spi_mosi, le, busy, ovf, err_addr}), 32'(exp_vec()));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
        if (le) le_seen++;
        if (mon_abort) begin
            in_txn = 1'b0; le_wait = 1'b0; mon_abort = 1'b0;
        end else begin
            if (prev_cs == 3'b111 && spi_cs_n != 3'b111) begin
                in_txn = 1'b1; cs_start = cyc; word = 32'd0; edges = 0;
            end else if (in_txn) begin
                if (!prev_sclk && spi_sclk) begin
                    word = {word[30:0], spi_mosi};
                    edges++;
                end
                if (spi_cs_n == 3'b111) begin
                    in_txn = 1'b0;
                    chk("cs_low_len", 32'(cyc - cs_start), 32'(65 * CD));
                    chk("sclk_edges", 32'(edges), 32'd32);
                    chk("spi_word_pending", 32'(exp_words.size() > 0), 32'd1);
                    if (exp_words.size() > 0) chk("spi_word", word, exp_words.pop_front());
                    txn_done++;
                    cs_rise = cyc;
                    le_wait = 1'b1;
                end
            end
            if (le_wait && !prev_le && le) begin
                chk("le_delay", 32'(cyc - cs_rise), 32'(CD));
                le_start = cyc;
            end
            if (le_wait && prev_le && !le) begin
                chk("le_width", 32'(cyc - le_start), 32'(LH));
                le_wait = 1'b0;
            end
        end
        prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_le = le;
    endtask

    initial forever begin
        @(negedge sys_clk);
        mon_step();
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d);
        cmd_valid = 1'b1; cmd_addr = a; cmd_mod = m; cmd_data = d;
    endtask

    task automatic send(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d);
        drive(a, m, d);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            if (busy_r == 0 && mq.size() == 0 && !busy) done = 1'b1;
            else step(1);
        end
        chk(tag, 32'(done), 32'd1);
        step(2);
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
    endtask

    initial begin
        int base;
        bit hit;
        // reset, with a command strobe that must be ignored
        step(2);
        drive(2'd1, 6'h2a, 24'hABCDEF);
        step(1);
        cmd_valid = 1'b0;
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'h7);
        chk("rst_flags", 32'({spi_sclk, spi_mosi, le, busy, ovf, err_addr}), 32'd0);
        sys_rst = 1'b1;
        step(2);

        // single write: cs_n[0] falls two edges after the strobe
        base = txn_done;
        drive(2'd0, 6'd1, 24'h123456);
        step(1);
        cmd_valid = 1'b0;
        chk("lat_e0_cs", 32'(spi_cs_n), 32'h7);
        step(1);
        chk("lat_e1_cs", 32'(spi_cs_n), 32'h7);
        step(1);
        chk("lat_e2_cs", 32'(spi_cs_n), 32'h6);
        wait_idle("idle_single");
        chk("single_txn", 32'(txn_done - base), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // queue ordering
        base = txn_done;
        peak = 0;
        send(2'd1, 6'h11, 24'h0F0F0F);
        send(2'd2, 6'h22, 24'hF0F0F0);
        send(2'd0, 6'h33, 24'h5A5A5A);
        wait_idle("idle_order");
        chk("order_peak", 32'(peak), 32'd2);
        chk("order_txns", 32'(txn_done - base), 32'd3);
        chk("order_ovf", 32'(ovf), 32'd0);

        // overflow: six strobes while idle, five accepted
        base = txn_done;
        for (int i = 0; i < 6; i++) send(2'(i % 3), 6'(i), 24'(32'h100 * i + 7));
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_cnt", 32'(fifo_cnt), 32'd4);
        pulse_clr();
        chk("ovf_clr", 32'(ovf), 32'd0);
        wait_idle("idle_ovf");
        chk("ovf_txns", 32'(txn_done - base), 32'd5);

        // invalid address, then a normal write
        base = txn_done;
        send(2'd3, 6'h3f, 24'hFFFFFF);
        step(3);
        chk("err_set", 32'(err_addr), 32'd1);
        chk("err_no_cs", 32'(spi_cs_n), 32'h7);
        send(2'd2, 6'h05, 24'hC0FFEE);
        wait_idle("idle_err");
        chk("err_txns", 32'(txn_done - base), 32'd1);
        pulse_clr();
        chk("err_clr", 32'(err_addr), 32'd0);

        // reset in the middle of SHIFT with one command queued
        send(2'd1, 6'h0c, 24'h987654);
        send(2'd0, 6'h0d, 24'h111111);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (busy_r > 0 && cur_valid && (DUR - busy_r) >= CD + 1 + 22 * CD) hit = 1'b1;
            else step(1);
        end
        chk("mid_shift_reached", 32'(hit), 32'd1);
        sys_rst = 1'b0;
        step(1);
        sys_rst = 1'b1;
        chk("rst_mid_cs", 32'(spi_cs_n), 32'h7);
        chk("rst_mid_outs", 32'({spi_sclk, spi_mosi, le, busy}), 32'd0);
        chk("rst_mid_cnt", 32'(fifo_cnt), 32'd0);
        le_seen = 0;
        step(300);
        chk("rst_mid_no_le", 32'(le_seen), 32'd0);

        // push and pop in the same cycle while full
        for (int i = 0; i < 5; i++) send(2'(i % 3), 6'(i + 8), 24'(32'hA00 + i));
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (busy_r == 0 && mq.size() == DEPTH) hit = 1'b1;
            else step(1);
        end
        chk("full_idle_reached", 32'(hit), 32'd1);
        send(2'd2, 6'h2e, 24'h0BEEF0);
        chk("full_pp_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_pp_ovf", 32'(ovf), 32'd0);
        wait_idle("idle_full");

        // randomized traffic
        for (int n = 0; n < 12; n++) begin
            send(2'($urandom_range(0, 3)), 6'($urandom), 24'($urandom));
            for (int g = $urandom_range(0, 400); g > 0; g--) begin
                ovf_clr = ($urandom_range(0, 15) == 0);
                step(1);
            end
            ovf_clr = 1'b0;
        end
        wait_idle("idle_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cfg_dispatch.md
CFG_DISPATCH -- requirements
Module: cfg_dispatch

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving spi_sclk half-period in sys_clk cycles (legal range 2..255).
REQ-002 SHALL have parameter LE_HOLD, default 10, giving the le pulse width in sys_clk cycles (legal range 1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving command queue depth (power of two).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: one-cycle command strobe from the UART frame decoder trig.
REQ-007 SHALL have ports cmd_addr (input, 2 bits), cmd_mod (input, 6 bits) and cmd_data (input, 24 bits): command fields, sampled when cmd_valid=1.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears ovf and err_addr.
REQ-009 SHALL have ports spi_sclk (output, 1 bit) and spi_mosi (output, 1 bit): serial clock and data to devices.
REQ-010 SHALL have port spi_cs_n, output, 3 bits: active-low select; bit n serves cmd_addr=n.
REQ-011 SHALL have port le, output, 1 bit: external latch/trigger pulse after each write.
REQ-012 SHALL have port busy, output, 1 bit: a write is in progress.
REQ-013 SHALL have ports ovf (output, 1 bit) and err_addr (output, 1 bit): sticky overflow and sticky invalid-address flags.
REQ-014 SHALL have port fifo_cnt, output, log2(FIFO_DEPTH)+1 bits: queued command count.

Function
REQ-015 SHALL push {cmd_addr,cmd_mod,cmd_data}, a 32-bit word, into the FIFO when cmd_valid=1 and (count<FIFO_DEPTH or a pop occurs the same cycle).
REQ-016 SHALL, on cmd_valid with FIFO full and no same-cycle pop, discard the command, leave the FIFO unchanged and set ovf=1.
REQ-017 SHALL give ovf_clr priority below a same-cycle new overflow or invalid-address event, so the flag stays 1.
REQ-018 SHALL implement the FSM states IDLE, LOAD, SETUP, SHIFT, HOLD, LATCH.
REQ-019 IDLE: when fifo_cnt>0, SHALL pop the head into a 32-bit shift register and go to LOAD.
REQ-020 LOAD, addr=3: SHALL set err_addr=1, drive no spi_cs_n and no le, and return to IDLE.
REQ-021 LOAD, addr 0..2: SHALL drive spi_cs_n[addr]=0 and spi_mosi=bit31, then go to SETUP.
REQ-022 Latency: spi_cs_n SHALL fall exactly 2 cycles after cmd_valid is sampled into an empty FIFO while IDLE.
REQ-023 SETUP SHALL last CLK_DIV cycles with spi_sclk=0, then go to SHIFT.
REQ-024 SHIFT, per bit, MSB first: SHALL hold spi_sclk=0 for CLK_DIV cycles, then spi_sclk=1 for CLK_DIV cycles.
REQ-025 SHIFT: spi_mosi SHALL change only on the cycle spi_sclk falls, so devices sample on the rising edge.
REQ-026 SHIFT: after the 32nd high phase, spi_sclk SHALL return to 0 and all spi_cs_n SHALL go to 1 on the same cycle, then the FSM goes to HOLD.
REQ-027 Chip-select timing: total spi_cs_n low time SHALL be CLK_DIV+64*CLK_DIV cycles, with exactly 32 spi_sclk rising edges.
REQ-028 HOLD SHALL last CLK_DIV cycles, then go to LATCH.
REQ-029 LATCH SHALL drive le=1 for exactly LE_HOLD cycles, then go to IDLE.
REQ-030 Back-to-back commands: the next pop SHALL occur on the first IDLE cycle, giving a 1-cycle IDLE gap.
REQ-031 busy SHALL be 1 in LOAD, SETUP, SHIFT, HOLD and LATCH, and 0 in IDLE.
REQ-032 Only one spi_cs_n bit SHALL ever be low at a time.
REQ-033 spi_sclk and spi_mosi SHALL be 0 outside SETUP and SHIFT.
REQ-034 A push during a write SHALL not disturb the write in progress.
REQ-035 The FIFO SHALL preserve command order.

Reset
REQ-036 SHALL, on sys_rst=0 at a clock edge, make state=IDLE, empty the FIFO (fifo_cnt=0), and set spi_cs_n=3'b111, spi_sclk=0, spi_mosi=0, le=0, busy=0, ovf=0, err_addr=0.
REQ-037 Reset mid-write SHALL abort immediately with no further sclk edges or le, and queued commands SHALL be lost.
REQ-038 cmd_valid during reset SHALL be ignored.

Verification
REQ-039 Single write, CLK_DIV=4, addr=0, mod=1, data=0x123456: cs_n[0] falls 2 cycles after cmd_valid and stays low 260 cycles; 32 rising sclk edges shift out 0x01123456 MSB first; le high 10 cycles starting 4 cycles after cs_n rises; busy then 0.
REQ-040 Queue ordering: 3 back-to-back cmd_valid with addr 1, 2, 0: writes appear in order on cs_n[1], cs_n[2], cs_n[0]; peak fifo_cnt=2; no ovf.
REQ-041 Overflow, FIFO_DEPTH=4: 6 consecutive cmd_valid while idle: 5 accepted (1 popped plus 4 queued), 1 dropped, ovf=1; ovf_clr pulse returns ovf to 0.
REQ-042 Invalid address: cmd_addr=3: no cs_n low, no sclk, no le; err_addr=1; a following addr=2 command executes normally.
REQ-043 Reset mid-SHIFT: assert sys_rst=0 after bit 10: on the next edge all outputs take their REQ-036 values, no le is produced, and fifo_cnt=0.
REQ-044 Simultaneous push and pop at full: FIFO full in IDLE with cmd_valid: command accepted, fifo_cnt stays at 4, ovf stays 0.
